// File: rtl/ws2812_multichannel_shifter.sv
// ws2812_multichannel_shifter
// ---------------------------------------------------------------------------
// Serialises one byte per channel onto CHANNELS parallel WS2812 data lines in
// lockstep. It generates the WS2812 bit timing and the inter-frame latch gap.
// The next byte set is prefetched during the last bit of each byte, so the
// bit stream has no gaps between bytes.
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-high reset
//   start         begin a frame (sampled only in IDLE)
//   enable        per-channel mask, latched when start is accepted
//   data          next byte per channel, channel i in data[8i+7:8i]
//   data_request  one-cycle pulse asking the source for the next byte set
//   busy          high from the cycle after start until the return to IDLE
//   frame_done    one-cycle pulse marking the end of the latch gap
//   dout          WS2812 data lines
//
// Optional feature: define WS2812_SHIFTER_INVERT_EN to add the 'invert' input.
// 'invert' is latched together with enable. Each dout line is then XORed with
// its invert bit at all times, including idle and masked periods. This suits
// inverting level shifters.
// ---------------------------------------------------------------------------
module ws2812_multichannel_shifter #(
   parameter int CHANNELS        = 4,
   parameter int BYTES_PER_FRAME = 24,
   parameter int BIT_CYCLES      = 15,
   parameter int T0H_CYCLES      = 4,
   parameter int T1H_CYCLES      = 9,
   parameter int RESET_CYCLES    = 3600
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CHANNELS-1:0]   enable,
`ifdef WS2812_SHIFTER_INVERT_EN
   input  logic [CHANNELS-1:0]   invert,
`endif
   input  logic [8*CHANNELS-1:0] data,
   output logic                  data_request,
   output logic                  busy,
   output logic                  frame_done,
   output logic [CHANNELS-1:0]   dout
);

   localparam int CYC_MAX = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
   localparam int CW      = $clog2(CYC_MAX);
   localparam int BW      = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;

   localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] LATCH_LAST = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0] T0H_C      = CW'(T0H_CYCLES);
   localparam logic [CW-1:0] T1H_C      = CW'(T1H_CYCLES);
   localparam logic [BW-1:0] LAST_BYTE  = BW'(BYTES_PER_FRAME - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_LATCH = 2'd3;

   logic [1:0]            state, state_n;
   logic                  fetch_wait, fetch_wait_n;
   logic [CW-1:0]         cyc, cyc_n;
   logic [2:0]            bit_idx, bit_n;
   logic [BW-1:0]         byte_cnt, byte_n;
   logic [8*CHANNELS-1:0] shreg, sh_n;
   logic [8*CHANNELS-1:0] hold, hold_n;
   logic [CHANNELS-1:0]   en_q, en_n;
   logic                  req_n, done_n;
   logic [CHANNELS-1:0]   dout_n;
`ifdef WS2812_SHIFTER_INVERT_EN
   logic [CHANNELS-1:0]   inv_q, inv_n;
`endif

   // Next-state logic. Every output is computed from the values the counters
   // will hold in the next cycle. The registered outputs therefore line up
   // exactly with the cycle they describe.
   always_comb begin
      state_n      = state;
      fetch_wait_n = fetch_wait;
      cyc_n        = cyc;
      bit_n        = bit_idx;
      byte_n       = byte_cnt;
      sh_n         = shreg;
      hold_n       = hold;
      en_n         = en_q;
      req_n        = 1'b0;
      done_n       = 1'b0;
`ifdef WS2812_SHIFTER_INVERT_EN
      inv_n        = inv_q;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n      = S_FETCH;
               fetch_wait_n = 1'b0;
               en_n         = enable;
               req_n        = 1'b1;
`ifdef WS2812_SHIFTER_INVERT_EN
               inv_n        = invert;
`endif
            end
         end
         S_FETCH: begin
            // The first FETCH cycle carries the request. The source answers
            // in the second cycle, and the byte set is captured at its end.
            if (!fetch_wait) begin
               fetch_wait_n = 1'b1;
            end else begin
               sh_n    = data;
               state_n = S_SHIFT;
               cyc_n   = '0;
               bit_n   = 3'd7;
               byte_n  = '0;
            end
         end
         S_SHIFT: begin
            // The prefetch answer arrives one cycle after the request issued
            // at the start of bit 0. BIT_CYCLES >= 3 guarantees that the
            // answer lands before the byte boundary.
            if (bit_idx == 3'd0 && cyc == CW'(1) && byte_cnt != LAST_BYTE)
               hold_n = data;
            if (cyc == BIT_LAST) begin
               cyc_n = '0;
               if (bit_idx == 3'd0) begin
                  if (byte_cnt == LAST_BYTE) begin
                     state_n = S_LATCH;
                  end else begin
                     byte_n = byte_cnt + 1'b1;
                     bit_n  = 3'd7;
                     sh_n   = hold;
                  end
               end else begin
                  bit_n = bit_idx - 3'd1;
               end
               if (bit_idx == 3'd1 && byte_cnt != LAST_BYTE)
                  req_n = 1'b1;
            end else begin
               cyc_n = cyc + 1'b1;
            end
         end
         default: begin
            if (cyc == LATCH_LAST) begin
               state_n = S_IDLE;
               cyc_n   = '0;
               done_n  = 1'b1;
            end else begin
               cyc_n = cyc + 1'b1;
            end
         end
      endcase

      dout_n = '0;
      if (state_n == S_SHIFT) begin
         for (int ch = 0; ch < CHANNELS; ch++)
            dout_n[ch] = en_n[ch] &&
                         (cyc_n < (sh_n[8*ch + int'(bit_n)] ? T1H_C : T0H_C));
      end
`ifdef WS2812_SHIFTER_INVERT_EN
      dout_n = dout_n ^ inv_n;
`endif
   end

   // State and output registers. Reset returns to IDLE at once, with every
   // output low, no matter where the frame was.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         fetch_wait   <= 1'b0;
         cyc          <= '0;
         bit_idx      <= 3'd0;
         byte_cnt     <= '0;
         shreg        <= '0;
         hold         <= '0;
         en_q         <= '0;
         data_request <= 1'b0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
         dout         <= '0;
`ifdef WS2812_SHIFTER_INVERT_EN
         inv_q        <= '0;
`endif
      end else begin
         state        <= state_n;
         fetch_wait   <= fetch_wait_n;
         cyc          <= cyc_n;
         bit_idx      <= bit_n;
         byte_cnt     <= byte_n;
         shreg        <= sh_n;
         hold         <= hold_n;
         en_q         <= en_n;
         data_request <= req_n;
         busy         <= (state_n != S_IDLE);
         frame_done   <= done_n;
         dout         <= dout_n;
`ifdef WS2812_SHIFTER_INVERT_EN
         inv_q        <= inv_n;
`endif
      end
   end

endmodule

// File: tb/tb_ws2812_multichannel_shifter.sv
// tb_ws2812_multichannel_shifter
// Bench for ws2812_multichannel_shifter with 2 channels and 2 bytes per frame.
// Expected waveforms are derived from the WS2812 timing rules: bit position,
// high time per bit value, latch gap and request points.
module tb_ws2812_multichannel_shifter;

   localparam int CH        = 2;
   localparam int NB        = 2;
   localparam int BITC      = 15;
   localparam int T0H       = 4;
   localparam int T1H       = 9;
   localparam int RST_C     = 20;
   localparam int DW        = 8 * CH;
   localparam int BYTE_LEN  = 8 * BITC;
   localparam int SHIFT_LEN = NB * BYTE_LEN;
   localparam int LAST_C    = 3 + SHIFT_LEN + RST_C;

   logic          clk, rst, start;
   logic [CH-1:0] enable;
   logic [DW-1:0] data;
   logic          data_request, busy, frame_done;
   logic [CH-1:0] dout;
`ifdef WS2812_SHIFTER_INVERT_EN
   logic [CH-1:0] invert;
`endif

   int checks, passes, fails;
   logic [7:0]    frameBytes [NB][CH];
   logic [CH-1:0] frameEn, frameInv, latchedInv;

   ws2812_multichannel_shifter #(
      .CHANNELS(CH), .BYTES_PER_FRAME(NB), .BIT_CYCLES(BITC),
      .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .RESET_CYCLES(RST_C)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .enable(enable),
`ifdef WS2812_SHIFTER_INVERT_EN
      .invert(invert),
`endif
      .data(data),
      .data_request(data_request),
      .busy(busy),
      .frame_done(frame_done),
      .dout(dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compares one observed value with its expected value and updates the counts.
   task automatic checkOutput(input string tag, input int cyc,
                              input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
      end
   endtask

   // Expected dout levels at time t, where t counts cycles from the first bit
   // of the frame.
   function automatic logic [CH-1:0] modelDout(input int t);
      logic [CH-1:0] lvl;
      lvl = '0;
      if (t >= 0 && t < SHIFT_LEN) begin
         int byteIdx, bitIdx, pos;
         byteIdx = t / BYTE_LEN;
         bitIdx  = 7 - (t % BYTE_LEN) / BITC;
         pos     = t % BITC;
         for (int c = 0; c < CH; c++) begin
            logic [7:0] b;
            b = frameBytes[byteIdx][c];
            if (frameEn[c] && pos < (b[bitIdx] ? T1H : T0H)) lvl[c] = 1'b1;
         end
      end
      return lvl ^ latchedInv;
   endfunction

   // Expected data_request. One request comes at the start of the fetch.
   // Another comes at the start of bit 0 of every byte except the last.
   function automatic logic modelRequest(input int c);
      int t;
      t = c - 3;
      if (c == 1) return 1'b1;
      return (t >= 0 && (t % BYTE_LEN) == 7 * BITC && (t / BYTE_LEN) < NB - 1);
   endfunction

   // Runs one frame from the cycle in which start is presented and checks
   // every cycle until frame_done. With keepStart set, start stays high for
   // the whole frame. pulseT pulses start once during shifting.
   task automatic applyStimulus(input bit keepStart, input int pulseT);
      start  = 1'b1;
      enable = frameEn;
`ifdef WS2812_SHIFTER_INVERT_EN
      invert = frameInv;
`endif
      for (int c = 1; c <= LAST_C; c++) begin
         int t;
         t = c - 3;
         @(negedge clk);
         if (c == 1) begin
            latchedInv = frameInv;
            start      = keepStart;
            enable     = CH'($urandom);
`ifdef WS2812_SHIFTER_INVERT_EN
            invert     = CH'($urandom);
`endif
         end
         checkOutput("dout", c, 32'(dout), 32'(modelDout(t)));
         checkOutput("busy", c, 32'(busy), 32'(c < LAST_C));
         checkOutput("data_request", c, 32'(data_request), 32'(modelRequest(c)));
         checkOutput("frame_done", c, 32'(frame_done), 32'(c == LAST_C));
         for (int k = 0; k < NB; k++) begin
            int rc;
            rc = (k == 0) ? 1 : 3 + (k - 1) * BYTE_LEN + 7 * BITC;
            if (c == rc) begin
               for (int ch = 0; ch < CH; ch++) data[8*ch +: 8] = frameBytes[k][ch];
            end else if (c == rc + 2) begin
               data = DW'($urandom);
            end
         end
         if (t == pulseT) start = 1'b1;
         else if (t == pulseT + 1) start = keepStart;
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checkOutput("idle_dout", i, 32'(dout), 32'(latchedInv));
         checkOutput("idle_busy", i, 32'(busy), 32'(0));
         checkOutput("idle_request", i, 32'(data_request), 32'(0));
         checkOutput("idle_frame_done", i, 32'(frame_done), 32'(0));
      end
   endtask

   task automatic randomBytes();
      for (int k = 0; k < NB; k++)
         for (int c = 0; c < CH; c++) frameBytes[k][c] = 8'($urandom);
   endtask

   initial begin
      checks = 0; passes = 0; fails = 0;
      rst = 1'b1; start = 1'b0; enable = '0; data = '0;
      frameInv = '0; latchedInv = '0; frameEn = '0;
`ifdef WS2812_SHIFTER_INVERT_EN
      invert = '0;
`endif
      repeat (2) @(negedge clk);
      checkOutput("rst_dout", 0, 32'(dout), 32'(0));
      checkOutput("rst_busy", 0, 32'(busy), 32'(0));
      checkOutput("rst_request", 0, 32'(data_request), 32'(0));
      checkOutput("rst_frame_done", 0, 32'(frame_done), 32'(0));
      rst = 1'b0;
      idleCycles(3);

      $display("[TB] frame with fixed bytes FF/00 then A5/5A");
      frameBytes[0][1] = 8'hFF; frameBytes[0][0] = 8'h00;
      frameBytes[1][1] = 8'hA5; frameBytes[1][0] = 8'h5A;
      frameEn = 2'b11;
      applyStimulus(1'b0, -100);
      idleCycles(5);

      $display("[TB] channel 1 masked");
      frameEn = 2'b01;
      applyStimulus(1'b0, -100);
      idleCycles(2);

      $display("[TB] random frames, start pulsed during shift and then held");
      randomBytes(); frameEn = CH'($urandom);
      applyStimulus(1'b1, 50);
      randomBytes(); frameEn = 2'b11;
      applyStimulus(1'b0, -100);
      idleCycles(4);

      $display("[TB] reset in the middle of byte 1");
      randomBytes(); frameEn = 2'b11; frameInv = '0;
      start = 1'b1; enable = frameEn;
      for (int c = 1; c <= 3 + BYTE_LEN + BITC; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start = 1'b0; latchedInv = '0;
            for (int ch = 0; ch < CH; ch++) data[8*ch +: 8] = frameBytes[0][ch];
         end
         if (c == 3 + 7 * BITC)
            for (int ch = 0; ch < CH; ch++) data[8*ch +: 8] = frameBytes[1][ch];
      end
      checkOutput("pre_rst_dout", 0, 32'(dout), 32'(modelDout(BYTE_LEN + BITC)));
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_dout", 0, 32'(dout), 32'(0));
      checkOutput("mid_rst_busy", 0, 32'(busy), 32'(0));
      checkOutput("mid_rst_request", 0, 32'(data_request), 32'(0));
      @(negedge clk);
      rst = 1'b0; latchedInv = '0;
      idleCycles(SHIFT_LEN + RST_C + 10);

      $display("[TB] clean frame after reset");
      randomBytes(); frameEn = CH'($urandom);
      applyStimulus(1'b0, -100);
      idleCycles(3);

`ifdef WS2812_SHIFTER_INVERT_EN
      $display("[TB] inverted channel 1 with byte 80");
      randomBytes(); frameBytes[0][1] = 8'h80; frameEn = 2'b11; frameInv = 2'b10;
      applyStimulus(1'b0, -100);
      idleCycles(5);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
